// File: rtl/thermal_sampler.sv
// thermal_sampler: polls a shared thermal ADC for every core in turn and boxcar-averages
// 2^AVG_LOG2 samples per core into a registered temperature with valid/hot/error flags.
// Latency: status outputs update in the cycle after adc_ack. Backpressure: the ADC stalls a
// request by withholding adc_ack, bounded to TIMEOUT cycles, after which the core is flagged.
//
// Ports:
//   CLK, RST    clock; synchronous active-high reset
//   adc_req     sample request to the shared ADC (high only in REQ)
//   adc_sel     core index being sampled, stable while adc_req is high
//   adc_ack     ADC sample available this cycle; adc_data valid with it
//   adc_data    raw ADC sample, top TEMP_W bits are degrees
//   temp_out    averaged temperatures, core i at [i*TEMP_W +: TEMP_W]
//   temp_valid  sticky, set on each core's first published average
//   hot         over-temperature flag with hysteresis
//   sensor_err  last request for that core timed out
//   round_done  one-cycle pulse after the last core of a round is serviced
module thermal_sampler #(
  parameter int NCORES     = 3,
  parameter int TEMP_W     = 8,
  parameter int ADC_W      = 10,
  parameter int AVG_LOG2   = 2,
  parameter int HOT_THRESH = 75,
  parameter int HYST       = 5,
  parameter int SAMPLE_GAP = 16,
  parameter int TIMEOUT    = 64,
  localparam int IDX_W     = (NCORES > 1) ? $clog2(NCORES) : 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  output logic                     adc_req,
  output logic [IDX_W-1:0]         adc_sel,
  input  logic                     adc_ack,
  input  logic [ADC_W-1:0]         adc_data,
  output logic [NCORES*TEMP_W-1:0] temp_out,
  output logic [NCORES-1:0]        temp_valid,
  output logic [NCORES-1:0]        hot,
  output logic [NCORES-1:0]        sensor_err,
  output logic                     round_done
);

  localparam int SUM_W  = TEMP_W + AVG_LOG2;
  localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int GAP_W  = (SAMPLE_GAP > 1) ? $clog2(SAMPLE_GAP + 1) : 1;
  localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int HOT_LO = HOT_THRESH - HYST;

  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NCORES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(SAMPLE_GAP);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  // Sequencer state
  state_t            state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [TO_W-1:0]   tcnt_q, tcnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              req_q, req_d;
  logic [IDX_W-1:0]  sel_q, sel_d;
  logic              done_q, done_d;

  // Per-core accumulators and published status
  logic [NCORES-1:0][SUM_W-1:0]  sum_q, sum_d;
  logic [NCORES-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [NCORES-1:0][TEMP_W-1:0] temp_q, temp_d;
  logic [NCORES-1:0]             valid_q, valid_d;
  logic [NCORES-1:0]             hot_q, hot_d;
  logic [NCORES-1:0]             err_q, err_d;

  // Request outcome this cycle: exactly one of these can be set, and only in REQ.
  logic take;
  logic tmo;

  logic [TEMP_W-1:0] sample;
  logic [SUM_W-1:0]  acc;
  logic [TEMP_W-1:0] avg;

  assign sample = adc_data[ADC_W-1 -: TEMP_W];

  if (ADC_W > TEMP_W) begin : g_unused_lsbs
    logic unused_lsbs;
    assign unused_lsbs = ^adc_data[ADC_W-TEMP_W-1:0];
  end

  // ---------------------------------------------------------------------------
  // Sequencer: next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    tcnt_d  = tcnt_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    take    = 1'b0;
    tmo     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (gap_q == '0) begin
          state_d = S_REQ;
          tcnt_d  = '0;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end

      S_REQ: begin
        // An ack arriving in the last allowed cycle still wins over the timeout.
        if (adc_ack) begin
          take = 1'b1;
        end else if (tcnt_q == TO_LAST) begin
          tmo = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end

        if (take || tmo) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_IDLE;
            idx_d   = '0;
            gap_d   = GAP_RELOAD;
            done_d  = 1'b1;
          end else begin
            state_d = S_SETTLE;
          end
        end
      end

      S_SETTLE: begin
        idx_d   = idx_q + 1'b1;
        tcnt_d  = '0;
        state_d = S_REQ;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Handshake outputs are registered copies of where the FSM is headed.
    req_d = (state_d == S_REQ);
    sel_d = idx_d;
  end

  // ---------------------------------------------------------------------------
  // Datapath: accumulate, publish averages, hysteresis and error flags
  // ---------------------------------------------------------------------------
  always_comb begin
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    temp_d  = temp_q;
    valid_d = valid_q;
    hot_d   = hot_q;
    err_d   = err_q;

    // SUM_W is wide enough for 2^AVG_LOG2 full-scale samples, so no overflow,
    // and its top TEMP_W bits are the floor of the window average.
    acc = sum_q[idx_q] + SUM_W'(sample);
    avg = acc[SUM_W-1 -: TEMP_W];

    if (take) begin
      err_d[idx_q] = 1'b0;
      if (cnt_q[idx_q] == CNT_LAST) begin
        temp_d[idx_q]  = avg;
        valid_d[idx_q] = 1'b1;
        sum_d[idx_q]   = '0;
        cnt_d[idx_q]   = '0;
        if (int'(avg) > HOT_THRESH) begin
          hot_d[idx_q] = 1'b1;
        end else if (int'(avg) < HOT_LO) begin
          hot_d[idx_q] = 1'b0;
        end
      end else begin
        sum_d[idx_q] = acc;
        cnt_d[idx_q] = cnt_q[idx_q] + 1'b1;
      end
    end else if (tmo) begin
      err_d[idx_q] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      tcnt_q  <= '0;
      idx_q   <= '0;
      req_q   <= 1'b0;
      sel_q   <= '0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cnt_q   <= '0;
      temp_q  <= '0;
      valid_q <= '0;
      hot_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      tcnt_q  <= tcnt_d;
      idx_q   <= idx_d;
      req_q   <= req_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      temp_q  <= temp_d;
      valid_q <= valid_d;
      hot_q   <= hot_d;
      err_q   <= err_d;
    end
  end

  assign adc_req    = req_q;
  assign adc_sel    = sel_q;
  assign temp_out   = temp_q;
  assign temp_valid = valid_q;
  assign hot        = hot_q;
  assign sensor_err = err_q;
  assign round_done = done_q;

endmodule

// File: tb/tb_thermal_sampler.sv
`timescale 1ns/1ps
module tb_thermal_sampler;

  localparam int NC      = 3;
  localparam int TW      = 8;
  localparam int AW      = 10;
  localparam int TIMEOUT = 64;
  localparam int GAP     = 16;
  localparam int NAVG    = 4;
  localparam int ADC_DIV = 4;   // adc_data >> (ADC_W - TEMP_W)
  localparam int HOT_SET = 75;
  localparam int HOT_CLR = 70;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          adc_ack = 1'b0;
  logic [AW-1:0] adc_data = '0;
  logic          adc_req;
  logic [1:0]    adc_sel;
  logic [NC*TW-1:0] temp_out;
  logic [NC-1:0] temp_valid;
  logic [NC-1:0] hot;
  logic [NC-1:0] sensor_err;
  logic          round_done;

  int checks   = 0;
  int errors   = 0;
  int rounds   = 0;
  int rd_seen  = 0;
  int next_low = -1;

  // Reference model: each core keeps the list of samples in its current window.
  int unsigned win [NC][$];
  int unsigned m_temp [NC];
  bit          m_valid [NC];
  bit          m_hot [NC];
  bit          m_err [NC];

  thermal_sampler dut (
    .CLK        (CLK),
    .RST        (RST),
    .adc_req    (adc_req),
    .adc_sel    (adc_sel),
    .adc_ack    (adc_ack),
    .adc_data   (adc_data),
    .temp_out   (temp_out),
    .temp_valid (temp_valid),
    .hot        (hot),
    .sensor_err (sensor_err),
    .round_done (round_done)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (round_done === 1'b1) rd_seen++;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rd();
    return int'($urandom_range(0, 1023));
  endfunction

  function automatic int rl();
    return int'($urandom_range(0, 4));
  endfunction

  function automatic bit ok();
    return ($urandom_range(0, 7) != 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      win[i].delete();
      m_temp[i]  = 0;
      m_valid[i] = 1'b0;
      m_hot[i]   = 1'b0;
      m_err[i]   = 1'b0;
    end
  endtask

  task automatic model_ack(input int core, input int data);
    int unsigned tot;
    int unsigned avg;
    m_err[core] = 1'b0;
    win[core].push_back(data / ADC_DIV);
    if (win[core].size() == NAVG) begin
      tot = 0;
      for (int k = 0; k < win[core].size(); k++) tot += win[core][k];
      avg = tot / NAVG;
      m_temp[core]  = avg;
      m_valid[core] = 1'b1;
      if (avg > HOT_SET)      m_hot[core] = 1'b1;
      else if (avg < HOT_CLR) m_hot[core] = 1'b0;
      win[core].delete();
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [NC*TW-1:0] et;
    logic [NC-1:0]    ev, eh, ee;
    for (int i = 0; i < NC; i++) begin
      et[i*TW +: TW] = TW'(m_temp[i]);
      ev[i] = m_valid[i];
      eh[i] = m_hot[i];
      ee[i] = m_err[i];
    end
    chk({tag, "_temp"},  temp_out,   et);
    chk({tag, "_valid"}, temp_valid, ev);
    chk({tag, "_hot"},   hot,        eh);
    chk({tag, "_err"},   sensor_err, ee);
  endtask

  // Entered at a negedge. Waits for the request (driving stray acks while adc_req
  // is low), then acks after lat cycles or lets it time out, and checks the
  // cycle after the request ends.
  task automatic serve(input int core, input int lat, input int data,
                       input bit give_ack, input int exp_low);
    int low;
    int hi;
    low = 0;
    while (adc_req !== 1'b1 && low < 400) begin
      if ($urandom_range(0, 3) == 0) begin
        adc_ack  = 1'b1;
        adc_data = AW'($urandom_range(0, 1023));
      end else begin
        adc_ack = 1'b0;
      end
      @(negedge CLK);
      low++;
    end
    adc_ack = 1'b0;
    chk("req_rise", adc_req, 1'b1);
    if (exp_low >= 0) chk("low_cycles", low, exp_low);
    chk("sel", adc_sel, core);
    if (give_ack) begin
      for (int k = 0; k < lat; k++) @(negedge CLK);
      chk("req_hold", adc_req, 1'b1);
      chk("sel_hold", adc_sel, core);
      adc_ack  = 1'b1;
      adc_data = AW'(data);
      @(negedge CLK);
      adc_ack = 1'b0;
      model_ack(core, data);
    end else begin
      hi = 0;
      while (adc_req === 1'b1 && hi < 200) begin
        @(negedge CLK);
        hi++;
      end
      chk("timeout_len", hi, TIMEOUT);
      m_err[core] = 1'b1;
    end
    chk("req_low_after", adc_req, 1'b0);
    chk("round_done", round_done, (core == NC - 1));
    if (core == NC - 1) rounds++;
    check_outputs("upd");
  endtask

  task automatic do_round(input int d0, input int d1, input int d2,
                          input int l0, input int l1, input int l2,
                          input bit a0, input bit a1, input bit a2);
    serve(0, l0, d0, a0, next_low);
    serve(1, l1, d1, a1, 1);
    serve(2, l2, d2, a2, 1);
    next_low = GAP + 1;
  endtask

  // Called at a negedge: one reset edge, check the reset cycle (which is also the
  // single IDLE cycle), release, then expect the first request on core 0.
  task automatic do_reset();
    RST     = 1'b1;
    adc_ack = 1'b0;
    @(negedge CLK);
    chk("rst_req",   adc_req,    1'b0);
    chk("rst_sel",   adc_sel,    2'd0);
    chk("rst_temp",  temp_out,   '0);
    chk("rst_valid", temp_valid, '0);
    chk("rst_hot",   hot,        '0);
    chk("rst_err",   sensor_err, '0);
    chk("rst_done",  round_done, 1'b0);
    model_reset();
    RST = 1'b0;
    @(negedge CLK);
    chk("first_req", adc_req, 1'b1);
    chk("first_sel", adc_sel, 2'd0);
    next_low = -1;
  endtask

  initial begin
    int w;
    model_reset();
    repeat (2) @(negedge CLK);
    do_reset();

    // Constant 300 on every core, ack in the first request cycle.
    repeat (4) do_round(300, 300, 300, 0, 0, 0, 1, 1, 1);
    chk("const_temp",  temp_out,   {8'd75, 8'd75, 8'd75});
    chk("const_valid", temp_valid, 3'b111);
    chk("const_hot",   hot,        3'b000);

    // Averaging and hysteresis on core 1.
    for (int r = 0; r < 4; r++) do_round(rd(), 304 + 16 * r, rd(), rl(), rl(), rl(), 1, 1, 1);
    chk("avg82_temp", temp_out[15:8], 8'd82);
    chk("avg82_hot",  hot[1], 1'b1);
    repeat (4) do_round(rd(), 280, rd(), rl(), rl(), rl(), 1, 1, 1);
    chk("hyst70_temp", temp_out[15:8], 8'd70);
    chk("hyst70_hot",  hot[1], 1'b1);
    repeat (4) do_round(rd(), 276, rd(), rl(), rl(), rl(), 1, 1, 1);
    chk("hyst69_temp", temp_out[15:8], 8'd69);
    chk("hyst69_hot",  hot[1], 1'b0);

    // Floor rounding on core 0, then a fresh window with no carry-over.
    for (int r = 0; r < 4; r++) do_round((r == 3) ? 8 : 4, rd(), rd(), rl(), rl(), rl(), 1, 1, 1);
    chk("floor_temp", temp_out[7:0], 8'd1);
    repeat (4) do_round(8, rd(), rd(), rl(), rl(), rl(), 1, 1, 1);
    chk("nocarry_temp", temp_out[7:0], 8'd2);

    // Timeout on core 2, recovery, and an ack in the final allowed cycle.
    do_round(rd(), rd(), 0, rl(), rl(), 0, 1, 1, 0);
    chk("tmo_err2",   sensor_err[2], 1'b1);
    chk("tmo_valid2", temp_valid[2], 1'b1);
    do_round(rd(), rd(), rd(), rl(), rl(), rl(), 1, 1, 1);
    chk("tmo_clear2", sensor_err[2], 1'b0);
    do_round(0, rd(), rd(), 0, rl(), rl(), 0, 1, 1);
    chk("tmo_err0", sensor_err[0], 1'b1);
    do_round(rd(), rd(), rd(), TIMEOUT - 1, rl(), rl(), 1, 1, 1);
    chk("late_ack_err0", sensor_err[0], 1'b0);

    // Randomized rounds with occasional timeouts.
    repeat (8) do_round(rd(), rd(), rd(), rl(), rl(), rl(), ok(), ok(), ok());

    // Reset with core 0 requesting and two of its four samples accumulated.
    do_reset();
    repeat (2) do_round(rd(), rd(), rd(), rl(), rl(), rl(), 1, 1, 1);
    w = 0;
    while (adc_req !== 1'b1 && w < 400) begin
      @(negedge CLK);
      w++;
    end
    chk("mid_req", adc_req, 1'b1);
    chk("mid_sel", adc_sel, 2'd0);
    do_reset();
    repeat (3) do_round(rd(), rd(), rd(), rl(), rl(), rl(), 1, 1, 1);
    chk("fresh_valid3", temp_valid, 3'b000);
    do_round(rd(), rd(), rd(), rl(), rl(), rl(), 1, 1, 1);
    chk("fresh_valid4", temp_valid, 3'b111);

    repeat (3) @(negedge CLK);
    chk("round_pulses", rd_seen, rounds);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
